event_sync_hub: RTL and testbench

- Multi-channel, synthesizable event synchronizer for testbench and DUT-side handshaking.
- Each of NUM_CH source channels raises triggers, either on rising edges of a level flag or on every high cycle.
- Each trigger is registered as a one-cycle pulse and queued in a saturating per-channel pending counter.
- Consumers drain triggers through a consume handshake; a per-channel repeat counter flags completion after REPEAT_N consumed events.

---
 rtl/event_sync_hub.sv | 158 +++++++++++++++
 tb/tb_event_sync_hub.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/event_sync_hub.sv
// event_sync_hub
//   Multi-channel event synchronizer. Each channel turns a level flag into
//   registered trigger pulses, queues them in a saturating pending counter,
//   and lets a consumer drain them one at a time. A per-channel repeat
//   counter raises a sticky done flag after REPEAT_N consumed events.
//
// Ports
//   clk            clock, all state on rising edge
//   rst_n          asynchronous active-low reset
//   clear_i        synchronous clear of counters and flags (highest priority)
//   ev_i           [NUM_CH]        per-channel event level
//   consume_i      [NUM_CH]        per-channel request to take one event
//   trig_o         [NUM_CH]        one-cycle registered trigger pulse
//   pending_o      [NUM_CH]        pending count nonzero
//   pend_cnt_o     [NUM_CH*CNT_W]  packed counts, channel c at [c*CNT_W +: CNT_W]
//   take_ack_o     [NUM_CH]        previous-cycle consume succeeded
//   ovf_o          [NUM_CH]        sticky: trigger dropped at saturation
//   done_o         [NUM_CH]        sticky: REPEAT_N events consumed
//   any_pending_o                  OR of pending_o
//   first_ch_o     [IDX_W]         lowest pending channel, 0 when none

// Per-channel slice: trigger detect, pending/repeat counters, flags.
module event_sync_ch #(
  parameter int CNT_W     = 4,
  parameter int REPEAT_N  = 5,
  parameter bit EDGE_MODE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             ev_i,
  input  logic             consume_i,
  output logic             trig_o,
  output logic [CNT_W-1:0] pend_cnt_o,
  output logic             take_ack_o,
  output logic             ovf_o,
  output logic             done_o
);
  localparam int RW = $clog2(REPEAT_N + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [RW-1:0]    REP_MAX = RW'(REPEAT_N);

  logic             prev_q;
  logic             trig_q, trig_d;
  logic             ack_q, ack_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RW-1:0]    rep_q, rep_d;
  logic             hit, take;

  // prev resets to 0, so a level already high right after reset is an edge.
  assign hit  = EDGE_MODE ? (ev_i & ~prev_q) : ev_i;
  assign take = consume_i & (cnt_q != '0);

  always_comb begin
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    rep_d  = rep_q;
    trig_d = hit & ~clear_i;
    ack_d  = take & ~clear_i;
    if (clear_i) begin
      cnt_d = '0;
      ovf_d = 1'b0;
      rep_d = '0;
    end else begin
      // hit+take cancel out: the take is serviced and the hit stays queued,
      // even at saturation.
      if (hit && !take) begin
        if (cnt_q == CNT_MAX) ovf_d = 1'b1;
        else                  cnt_d = cnt_q + 1'b1;
      end else if (take && !hit) begin
        cnt_d = cnt_q - 1'b1;
      end
      if (take && (rep_q != REP_MAX)) rep_d = rep_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
      trig_q <= 1'b0;
      ack_q  <= 1'b0;
      ovf_q  <= 1'b0;
      cnt_q  <= '0;
      rep_q  <= '0;
    end else begin
      // prev tracks the level even during clear so a held level does not
      // re-trigger once clear drops.
      prev_q <= ev_i;
      trig_q <= trig_d;
      ack_q  <= ack_d;
      ovf_q  <= ovf_d;
      cnt_q  <= cnt_d;
      rep_q  <= rep_d;
    end
  end

  assign trig_o     = trig_q;
  assign pend_cnt_o = cnt_q;
  assign take_ack_o = ack_q;
  assign ovf_o      = ovf_q;
  assign done_o     = (rep_q == REP_MAX);
endmodule

module event_sync_hub #(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = 4,
  parameter int REPEAT_N  = 5,
  parameter bit EDGE_MODE = 1'b1,
  parameter int IDX_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear_i,
  input  logic [NUM_CH-1:0]       ev_i,
  input  logic [NUM_CH-1:0]       consume_i,
  output logic [NUM_CH-1:0]       trig_o,
  output logic [NUM_CH-1:0]       pending_o,
  output logic [NUM_CH*CNT_W-1:0] pend_cnt_o,
  output logic [NUM_CH-1:0]       take_ack_o,
  output logic [NUM_CH-1:0]       ovf_o,
  output logic [NUM_CH-1:0]       done_o,
  output logic                    any_pending_o,
  output logic [IDX_W-1:0]        first_ch_o
);
  logic [NUM_CH-1:0][CNT_W-1:0] pend_cnt;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    event_sync_ch #(
      .CNT_W     (CNT_W),
      .REPEAT_N  (REPEAT_N),
      .EDGE_MODE (EDGE_MODE)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear_i    (clear_i),
      .ev_i       (ev_i[c]),
      .consume_i  (consume_i[c]),
      .trig_o     (trig_o[c]),
      .pend_cnt_o (pend_cnt[c]),
      .take_ack_o (take_ack_o[c]),
      .ovf_o      (ovf_o[c]),
      .done_o     (done_o[c])
    );
    assign pending_o[c] = (pend_cnt[c] != '0);
  end

  assign pend_cnt_o    = pend_cnt;
  assign any_pending_o = |pending_o;

  // Fixed priority, index 0 wins: scan downward so the lowest hit is last.
  always_comb begin
    first_ch_o = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (pending_o[c]) first_ch_o = IDX_W'(c);
    end
  end
endmodule

// File: tb/tb_event_sync_hub.sv
module tb_event_sync_hub;
  logic clk, rst_n, clear_i;

  // main: 4 channels, edge mode, CNT_W=4, REPEAT_N=5
  logic [3:0]  ev, cons, trig, pend, ack, ovf, done;
  logic [15:0] cnt;
  logic        anyp;
  logic [1:0]  first;
  // level mode, single channel
  logic        ev_l, cons_l, trig_l, pend_l, ack_l, ovf_l, done_l, any_l, first_l;
  logic [3:0]  cnt_l;
  // saturation, CNT_W=2, single channel
  logic        ev_s, cons_s, trig_s, pend_s, ack_s, ovf_s, done_s, any_s, first_s;
  logic [1:0]  cnt_s;

  int vecs = 0;
  int errs = 0;

  event_sync_hub #(.NUM_CH(4), .CNT_W(4), .REPEAT_N(5), .EDGE_MODE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .clear_i(clear_i), .ev_i(ev), .consume_i(cons),
    .trig_o(trig), .pending_o(pend), .pend_cnt_o(cnt), .take_ack_o(ack),
    .ovf_o(ovf), .done_o(done), .any_pending_o(anyp), .first_ch_o(first));

  event_sync_hub #(.NUM_CH(1), .CNT_W(4), .REPEAT_N(5), .EDGE_MODE(1'b0)) dut_lvl (
    .clk(clk), .rst_n(rst_n), .clear_i(clear_i), .ev_i(ev_l), .consume_i(cons_l),
    .trig_o(trig_l), .pending_o(pend_l), .pend_cnt_o(cnt_l), .take_ack_o(ack_l),
    .ovf_o(ovf_l), .done_o(done_l), .any_pending_o(any_l), .first_ch_o(first_l));

  event_sync_hub #(.NUM_CH(1), .CNT_W(2), .REPEAT_N(5), .EDGE_MODE(1'b1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .clear_i(clear_i), .ev_i(ev_s), .consume_i(cons_s),
    .trig_o(trig_s), .pending_o(pend_s), .pend_cnt_o(cnt_s), .take_ack_o(ack_s),
    .ovf_o(ovf_s), .done_o(done_s), .any_pending_o(any_s), .first_ch_o(first_s));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b0; clear_i = 1'b0;
    ev = '0; cons = '0; ev_l = 0; cons_l = 0; ev_s = 0; cons_s = 0;
    tick(2);
    // reset state
    chk("rst_main", {trig, pend, ack, ovf, done, cnt, anyp, first}, 32'h0);
    chk("rst_lvl",  {trig_l, pend_l, cnt_l, ack_l, ovf_l, done_l, any_l, first_l}, 32'h0);
    chk("rst_sat",  {trig_s, pend_s, cnt_s, ack_s, ovf_s, done_s, any_s, first_s}, 32'h0);
    rst_n = 1'b1;

    // edge mode: 0(10) 1(20) 0(30) 1(...) on ch0
    tick(10);
    chk("edge_idle_trig", trig, 4'h0);
    ev[0] = 1'b1;
    tick();
    chk("edge_rise1_trig", trig, 4'h1);
    chk("edge_rise1_cnt", cnt, 16'h0001);
    tick();
    chk("edge_pulse1_width", trig, 4'h0);
    tick(18);
    chk("edge_held_trig", trig, 4'h0);
    ev[0] = 1'b0;
    tick(30);
    chk("edge_low_cnt", cnt, 16'h0001);
    ev[0] = 1'b1;
    tick();
    chk("edge_rise2_trig", trig, 4'h1);
    chk("edge_rise2_cnt", cnt, 16'h0002);
    chk("edge_pending", {anyp, first, pend}, {1'b1, 2'd0, 4'h1});
    tick();
    chk("edge_pulse2_width", trig, 4'h0);

    // clear with ch0 level still high: no re-trigger afterwards
    clear_i = 1'b1;
    tick();
    chk("clr_cnt", cnt, 16'h0);
    clear_i = 1'b0;
    tick();
    chk("clr_no_retrig", {trig, cnt}, 20'h0);
    ev[0] = 1'b0;

    // level mode: 3 high cycles -> 3 pulses
    ev_l = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("lvl_trig", trig_l, 1'b1);
      chk("lvl_cnt", cnt_l, 4'(i));
    end
    ev_l = 1'b0;
    tick();
    chk("lvl_trig_off", {trig_l, cnt_l}, {1'b0, 4'd3});
    cons_l = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("lvl_ack", ack_l, 1'b1);
      chk("lvl_drain_cnt", cnt_l, 4'(3 - i));
    end
    tick();
    chk("lvl_empty_consume", {ack_l, cnt_l, pend_l}, 6'h0);
    cons_l = 1'b0;

    // saturation at CNT_W=2: 5 edges, ovf on the 4th
    for (int n = 1; n <= 5; n++) begin
      ev_s = 1'b1;
      tick();
      chk("sat_cnt", cnt_s, (n >= 3) ? 2'd3 : 2'(n));
      chk("sat_ovf", ovf_s, (n >= 4) ? 1'b1 : 1'b0);
      ev_s = 1'b0;
      tick();
    end
    ev_s = 1'b1; cons_s = 1'b1;
    tick();
    chk("sat_hit_take", {cnt_s, ack_s, trig_s, ovf_s}, {2'd3, 1'b1, 1'b1, 1'b1});
    ev_s = 1'b0; cons_s = 1'b0;
    tick();

    // repeat on ch1: each event consumed one cycle later
    for (int k = 1; k <= 6; k++) begin
      ev[1] = 1'b1;
      tick();
      chk("rep_hit_cnt", cnt, 16'h0010);
      ev[1] = 1'b0; cons[1] = 1'b1;
      tick();
      chk("rep_ack", {ack, cnt}, {4'h2, 16'h0});
      chk("rep_done", done, (k >= 5) ? 4'h2 : 4'h0);
      cons[1] = 1'b0;
    end
    clear_i = 1'b1;
    tick();
    chk("rep_clr_done", {done, ack}, 8'h0);
    chk("sat_clr", {ovf_s, cnt_s, pend_s}, 4'h0);
    clear_i = 1'b0;
    tick();

    // multi-channel priority
    ev[2] = 1'b1; ev[3] = 1'b1;
    tick();
    ev = '0;
    chk("mc_cnt", cnt, 16'h1100);
    chk("mc_first2", {anyp, first}, {1'b1, 2'd2});
    cons[2] = 1'b1;
    tick();
    chk("mc_first3", {anyp, first, pend}, {1'b1, 2'd3, 4'h8});
    cons[2] = 1'b0; cons[3] = 1'b1;
    tick();
    chk("mc_none", {anyp, first, pend}, 7'h0);
    cons[3] = 1'b0;

    // mid-operation async reset
    ev[0] = 1'b1;
    tick();
    ev[0] = 1'b0;
    tick();
    ev[0] = 1'b1;
    tick();
    chk("mr_pre", {trig, cnt}, {4'h1, 16'h0002});
    #2 rst_n = 1'b0;
    #1;
    chk("mr_async", {trig, pend, ack, ovf, done, cnt, anyp, first}, 32'h0);
    tick(2);
    rst_n = 1'b1;
    tick();
    chk("mr_retrig", {trig, cnt}, {4'h1, 16'h0001});
    tick();
    chk("mr_single", {trig, cnt}, {4'h0, 16'h0001});
    ev = '0;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
